// File: rtl/host_run_controller_pkg.sv
// Shared state codes and widths for the host run sequencer.
package host_ctrl_pkg;

    localparam int STATE_W       = 3;
    localparam int RUN_CNT_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_IMEM = 3'd1,
        ST_LOAD_DMEM = 3'd2,
        ST_EXEC      = 3'd3,
        ST_UNLOAD    = 3'd4,
        ST_FINISH    = 3'd5,
        ST_ERROR     = 3'd6
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LOAD_IMEM) || (s == ST_LOAD_DMEM) ||
               (s == ST_EXEC)      || (s == ST_UNLOAD);
    endfunction

endpackage

// File: rtl/host_run_controller_if.sv
// Memory port bundle: UART and processor requests in, muxed memory ports out.
interface host_run_controller_if #(
    parameter int DATA_MEM_WIDTH      = 24,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_MEM_ADDR_WIDTH  = 8
);
    logic [DATA_MEM_ADDR_WIDTH-1:0] uart_dmem_addr, proc_dmem_addr, dmem_addr;
    logic                           uart_dmem_we, proc_dmem_we, dmem_we;
    logic [DATA_MEM_WIDTH-1:0]      uart_dmem_wdata, proc_dmem_wdata, dmem_wdata;
    logic [INS_MEM_ADDR_WIDTH-1:0]  uart_imem_addr, proc_imem_addr, imem_addr;
    logic                           uart_imem_we, imem_we;

    // master: the controller that owns the memory ports
    modport master (
        input  uart_dmem_addr, uart_dmem_we, uart_dmem_wdata,
        input  proc_dmem_addr, proc_dmem_we, proc_dmem_wdata,
        input  uart_imem_addr, proc_imem_addr, uart_imem_we,
        output dmem_addr, dmem_we, dmem_wdata, imem_addr, imem_we
    );

    modport slave (
        output uart_dmem_addr, uart_dmem_we, uart_dmem_wdata,
        output proc_dmem_addr, proc_dmem_we, proc_dmem_wdata,
        output uart_imem_addr, proc_imem_addr, uart_imem_we,
        input  dmem_addr, dmem_we, dmem_wdata, imem_addr, imem_we
    );
endinterface

// File: rtl/host_run_controller_counter.sv
// Saturating execution cycle counter with a look-ahead timeout compare.
module run_cycle_counter #(
    parameter int CNT_WIDTH      = 26,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 hit_o
);
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && (count_q != '1))
            count_d = count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstN) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

    // Compare the next value so the FSM leaves EXEC with the count frozen at the limit.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
        assign hit_o = 1'b0;
    end else begin : g_timeout
        assign hit_o = en_i && !clr_i && (count_d == CNT_WIDTH'(TIMEOUT_CYCLES));
    end

endmodule

// File: rtl/host_run_controller.sv
// Run sequencer: load imem, load dmem, execute, unload; owns and muxes both memory ports.
module host_run_controller
    import host_ctrl_pkg::*;
#(
    parameter int DATA_MEM_WIDTH      = 24,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_WIDTH           = 8,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int CNT_WIDTH           = 26,
    parameter int TIMEOUT_CYCLES      = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     reload_imem,
    input  logic                     imem_rx_done,
    input  logic                     dmem_rx_done,
    input  logic                     proc_done,
    input  logic                     dmem_tx_done,
    input  logic                     new_byte,
    output logic                     new_ins_byte,
    output logic                     new_data_byte,
    host_run_controller_if.master    mem_bus,
    output logic                     proc_start,
    output logic                     tx_start,
    output logic [STATE_W-1:0]       state,
    output logic                     busy,
    output logic                     error,
    output logic [CNT_WIDTH-1:0]     cycle_count,
    output logic [RUN_CNT_WIDTH-1:0] run_count
);
    localparam logic [DATA_MEM_ADDR_WIDTH-1:0] DADDR_ZERO = '0;
    localparam logic [DATA_MEM_WIDTH-1:0]      DDATA_ZERO = '0;
    localparam logic [INS_MEM_ADDR_WIDTH-1:0]  IADDR_ZERO = '0;

    if (INS_WIDTH < 1) begin : g_bad_ins_width
        $error("INS_WIDTH must be positive");
    end

    state_e                   state_q;
    logic                     proc_start_q, tx_start_q;
    logic [RUN_CNT_WIDTH-1:0] run_count_q;
    logic                     cnt_clr, cnt_en, cnt_hit;

    assign cnt_clr = (state_q == ST_LOAD_DMEM) && dmem_rx_done && !abort;
    assign cnt_en  = (state_q == ST_EXEC);

    run_cycle_counter #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cycle_counter (
        .clk     (clk),
        .rstN    (rstN),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cycle_count),
        .hit_o   (cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= ST_IDLE;
            proc_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            run_count_q  <= '0;
        end else begin
            proc_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:      if (start) state_q <= ST_LOAD_IMEM;
                    ST_LOAD_IMEM: if (imem_rx_done) state_q <= ST_LOAD_DMEM;
                    ST_LOAD_DMEM: if (dmem_rx_done) begin
                        state_q      <= ST_EXEC;
                        proc_start_q <= 1'b1;
                    end
                    ST_EXEC: if (proc_done) begin
                        state_q    <= ST_UNLOAD;
                        tx_start_q <= 1'b1;
                    end else if (cnt_hit) begin
                        state_q <= ST_ERROR;
                    end
                    ST_UNLOAD: if (dmem_tx_done) begin
                        state_q     <= ST_FINISH;
                        run_count_q <= run_count_q + RUN_CNT_WIDTH'(1);
                    end
                    // Repeat runs keep the already-loaded program unless asked otherwise.
                    ST_FINISH: if (start) state_q <= reload_imem ? ST_LOAD_IMEM : ST_LOAD_DMEM;
                    ST_ERROR:  if (start) state_q <= ST_IDLE;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        mem_bus.dmem_addr  = DADDR_ZERO;
        mem_bus.dmem_we    = 1'b0;
        mem_bus.dmem_wdata = DDATA_ZERO;
        mem_bus.imem_addr  = IADDR_ZERO;
        mem_bus.imem_we    = 1'b0;
        case (state_q)
            ST_LOAD_IMEM: begin
                mem_bus.imem_addr = mem_bus.uart_imem_addr;
                mem_bus.imem_we   = mem_bus.uart_imem_we;
            end
            ST_LOAD_DMEM, ST_UNLOAD: begin
                mem_bus.dmem_addr  = mem_bus.uart_dmem_addr;
                mem_bus.dmem_we    = mem_bus.uart_dmem_we;
                mem_bus.dmem_wdata = mem_bus.uart_dmem_wdata;
            end
            ST_EXEC: begin
                mem_bus.dmem_addr  = mem_bus.proc_dmem_addr;
                mem_bus.dmem_we    = mem_bus.proc_dmem_we;
                mem_bus.dmem_wdata = mem_bus.proc_dmem_wdata;
                mem_bus.imem_addr  = mem_bus.proc_imem_addr;
            end
            default: ;
        endcase
    end

    assign new_ins_byte  = new_byte && (state_q == ST_LOAD_IMEM);
    assign new_data_byte = new_byte && (state_q == ST_LOAD_DMEM);
    assign proc_start    = proc_start_q;
    assign tx_start      = tx_start_q;
    assign state         = state_q;
    assign busy          = is_busy(state_q);
    assign error         = (state_q == ST_ERROR);
    assign run_count     = run_count_q;

endmodule

// File: tb/tb_host_run_controller.sv
// Drives two controllers (no timeout / timeout 50) from one stimulus stream and checks them.
module tb_host_run_controller;
    localparam int DW = 24, DA = 12, IA = 8, CW = 26, TMO_B = 50;
    localparam longint CMAX = (64'd1 << CW) - 1;

    typedef struct packed {
        logic [2:0]    st;
        logic          busy, err, ps, ts, nib, ndb;
        logic [CW-1:0] cc;
        logic [7:0]    rc;
        logic [DA-1:0] da;
        logic          dwe;
        logic [DW-1:0] dwd;
        logic [IA-1:0] ia;
        logic          iwe;
    } obs_t;

    typedef struct { int ph; longint cyc; int runs; bit ps; bit ts; } mdl_t;
    typedef struct { logic [6:0] ctl; int st; bit ps; bit ts; } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, start, abort, reload_imem, imem_rx_done, dmem_rx_done, proc_done, dmem_tx_done, new_byte;
    logic [DA-1:0] u_da, p_da;
    logic          u_dwe, p_dwe, u_iwe;
    logic [DW-1:0] u_dwd, p_dwd;
    logic [IA-1:0] u_ia, p_ia;

    obs_t [1:0] obs;
    mdl_t m [2];
    int   tmo [2] = '{0, TMO_B};
    int   total = 0, bad = 0;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dut
        host_run_controller_if #(.DATA_MEM_WIDTH(DW), .DATA_MEM_ADDR_WIDTH(DA), .INS_MEM_ADDR_WIDTH(IA)) bus ();
        logic [2:0] st_w;
        logic busy_w, err_w, ps_w, ts_w, nib_w, ndb_w;
        logic [CW-1:0] cc_w;
        logic [7:0] rc_w;
        assign bus.uart_dmem_addr = u_da;  assign bus.uart_dmem_we = u_dwe; assign bus.uart_dmem_wdata = u_dwd;
        assign bus.proc_dmem_addr = p_da;  assign bus.proc_dmem_we = p_dwe; assign bus.proc_dmem_wdata = p_dwd;
        assign bus.uart_imem_addr = u_ia;  assign bus.proc_imem_addr = p_ia; assign bus.uart_imem_we = u_iwe;
        host_run_controller #(
            .DATA_MEM_WIDTH(DW), .DATA_MEM_ADDR_WIDTH(DA), .INS_WIDTH(8), .INS_MEM_ADDR_WIDTH(IA),
            .CNT_WIDTH(CW), .TIMEOUT_CYCLES(gi == 0 ? 0 : TMO_B)
        ) dut (
            .clk(clk), .rstN(rstN), .start(start), .abort(abort), .reload_imem(reload_imem),
            .imem_rx_done(imem_rx_done), .dmem_rx_done(dmem_rx_done), .proc_done(proc_done),
            .dmem_tx_done(dmem_tx_done), .new_byte(new_byte), .new_ins_byte(nib_w),
            .new_data_byte(ndb_w), .mem_bus(bus), .proc_start(ps_w), .tx_start(ts_w),
            .state(st_w), .busy(busy_w), .error(err_w), .cycle_count(cc_w), .run_count(rc_w)
        );
        assign obs[gi] = '{st: st_w, busy: busy_w, err: err_w, ps: ps_w, ts: ts_w, nib: nib_w,
                           ndb: ndb_w, cc: cc_w, rc: rc_w, da: bus.dmem_addr, dwe: bus.dmem_we,
                           dwd: bus.dmem_wdata, ia: bus.imem_addr, iwe: bus.imem_we};
    end

    // Expected outputs from the phase rules: who owns each memory port in each phase.
    function automatic obs_t expect_of(mdl_t s);
        obs_t e = '0;
        e.st   = 3'(s.ph);
        e.busy = (s.ph >= 1) && (s.ph <= 4);
        e.err  = (s.ph == 6);
        e.ps   = s.ps;
        e.ts   = s.ts;
        e.nib  = (s.ph == 1) && new_byte;
        e.ndb  = (s.ph == 2) && new_byte;
        e.cc   = CW'(s.cyc);
        e.rc   = 8'(s.runs);
        if (s.ph == 2 || s.ph == 4) begin e.da = u_da; e.dwe = u_dwe; e.dwd = u_dwd; end
        if (s.ph == 3) begin e.da = p_da; e.dwe = p_dwe; e.dwd = p_dwd; e.ia = p_ia; end
        if (s.ph == 1) begin e.ia = u_ia; e.iwe = u_iwe; end
        return e;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_obs(input string nm, input int k, input obs_t exp);
        total++;
        if (obs[k] !== exp) begin
            bad++;
            $display("FAIL %s dut%0d act st=%0d cc=%0d rc=%0d obs=%h exp st=%0d cc=%0d rc=%0d obs=%h",
                     nm, k, obs[k].st, obs[k].cc, obs[k].rc, obs[k], exp.st, exp.cc, exp.rc, exp);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            mdl_t n = m[k];
            if (!rstN) begin
                n = '{0, 0, 0, 0, 0};
            end else begin
                n.ps = 0;
                n.ts = 0;
                if (m[k].ph == 3) n.cyc = (m[k].cyc == CMAX) ? CMAX : m[k].cyc + 1;
                if (abort && m[k].ph != 0) n.ph = 0;
                else case (m[k].ph)
                    0: if (start) n.ph = 1;
                    1: if (imem_rx_done) n.ph = 2;
                    2: if (dmem_rx_done) begin n.ph = 3; n.cyc = 0; n.ps = 1; end
                    3: if (proc_done) begin n.ph = 4; n.ts = 1; end
                       else if (tmo[k] != 0 && n.cyc == tmo[k]) n.ph = 6;
                    4: if (dmem_tx_done) begin n.ph = 5; n.runs = (m[k].runs + 1) % 256; end
                    5: if (start) n.ph = reload_imem ? 1 : 2;
                    6: if (start) n.ph = 0;
                    default: n.ph = 0;
                endcase
            end
            m[k] = n;
        end
    endtask

    // Check current cycle against the model, advance one clock, drop the pulse inputs.
    task automatic step();
        #1;
        chk_obs("model", 0, expect_of(m[0]));
        chk_obs("model", 1, expect_of(m[1]));
        model_update();
        @(negedge clk);
        {start, abort, imem_rx_done, dmem_rx_done, proc_done, dmem_tx_done, new_byte} = '0;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        step();
        rstN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    vec_t vecs [19];
    int psc, tsc, prev_runs;

    initial begin
        {rstN, start, abort, reload_imem, imem_rx_done, dmem_rx_done, proc_done, dmem_tx_done, new_byte} = '0;
        {u_da, p_da, u_dwe, p_dwe, u_iwe, u_dwd, p_dwd, u_ia, p_ia} = '0;
        for (int k = 0; k < 2; k++) m[k] = '{0, 0, 0, 0, 0};
        @(negedge clk);

        u_da = 12'hA5A; u_dwe = 1; u_dwd = 24'h123456; u_ia = 8'h3C; u_iwe = 1;
        p_da = 12'h5A5; p_dwe = 1; p_dwd = 24'h654321; p_ia = 8'hC3; new_byte = 1;
        #1;
        chk_obs("reset_values", 0, '0);
        chk_obs("reset_values", 1, '0);
        $display("reset state checked");
        rstN = 1'b1;

        // {start, abort, reload, imem_rx, dmem_rx, proc_done, tx_done} -> next state, proc_start, tx_start
        vecs[0]  = '{7'b0001000, 0, 0, 0};
        vecs[1]  = '{7'b0000010, 0, 0, 0};
        vecs[2]  = '{7'b1000000, 1, 0, 0};
        vecs[3]  = '{7'b1000100, 1, 0, 0};
        vecs[4]  = '{7'b0001000, 2, 0, 0};
        vecs[5]  = '{7'b0000000, 2, 0, 0};
        vecs[6]  = '{7'b0000100, 3, 1, 0};
        vecs[7]  = '{7'b0000000, 3, 0, 0};
        vecs[8]  = '{7'b0000001, 3, 0, 0};
        vecs[9]  = '{7'b0000010, 4, 0, 1};
        vecs[10] = '{7'b1000000, 4, 0, 0};
        vecs[11] = '{7'b0000001, 5, 0, 0};
        vecs[12] = '{7'b1000000, 2, 0, 0};
        vecs[13] = '{7'b0100000, 0, 0, 0};
        vecs[14] = '{7'b1100000, 1, 0, 0};
        vecs[15] = '{7'b0001000, 2, 0, 0};
        vecs[16] = '{7'b0100100, 0, 0, 0};
        vecs[17] = '{7'b1010000, 1, 0, 0};
        vecs[18] = '{7'b0101000, 0, 0, 0};
        for (int i = 0; i < 19; i++) begin
            {start, abort, reload_imem, imem_rx_done, dmem_rx_done, proc_done, dmem_tx_done} = vecs[i].ctl;
            step();
            chk($sformatf("vec%0d_state", i), obs[0].st, vecs[i].st);
            chk($sformatf("vec%0d_proc_start", i), obs[0].ps, vecs[i].ps);
            chk($sformatf("vec%0d_tx_start", i), obs[0].ts, vecs[i].ts);
            $display("vec %0d ctl=%b state=%0d", i, vecs[i].ctl, obs[0].st);
        end

        // Full run with proc_done in the 100th execute cycle; dut1 times out at 50.
        do_reset();
        start = 1; step(); chk("run_load_imem", obs[0].st, 1);
        imem_rx_done = 1; step(); chk("run_load_dmem", obs[0].st, 2);
        dmem_rx_done = 1; step();
        chk("run_exec", obs[0].st, 3);
        chk("run_proc_start", obs[0].ps, 1);
        chk("run_cc_clear", obs[0].cc, 0);
        psc = obs[0].ps; tsc = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 100) proc_done = 1;
            step();
            psc += obs[0].ps; tsc += obs[0].ts;
            if (i == 49) chk("tmo_still_exec", obs[1].st, 3);
            if (i == 50) begin
                chk("tmo_error_state", obs[1].st, 6);
                chk("tmo_error_flag", obs[1].err, 1);
                chk("tmo_count", obs[1].cc, TMO_B);
            end
        end
        chk("run_unload", obs[0].st, 4);
        chk("run_cycle_count", obs[0].cc, 100);
        dmem_tx_done = 1; step(); tsc += obs[0].ts;
        chk("run_finish", obs[0].st, 5);
        chk("run_count_1", obs[0].rc, 1);
        chk("run_proc_start_pulses", psc, 1);
        chk("run_tx_start_pulses", tsc, 1);
        chk("tmo_count_hold", obs[1].cc, TMO_B);
        $display("full run: cycles=%0d runs=%0d", obs[0].cc, obs[0].rc);

        // Repeat run without instruction reload; start also clears dut1's error.
        start = 1; reload_imem = 0; step();
        chk("repeat_skip_imem", obs[0].st, 2);
        chk("error_start_idle", obs[1].st, 0);
        dmem_rx_done = 1; step(); chk("repeat_exec", obs[0].st, 3);
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) proc_done = 1;
            step();
        end
        chk("repeat_unload", obs[0].st, 4);
        chk("repeat_cycles", obs[0].cc, 10);
        dmem_tx_done = 1; step();
        chk("repeat_run_count", obs[0].rc, 2);
        $display("repeat run: runs=%0d", obs[0].rc);

        // Abort together with proc_done in EXEC.
        start = 1; reload_imem = 1; step(); chk("abort_load_imem", obs[0].st, 1);
        imem_rx_done = 1; step();
        dmem_rx_done = 1; step();
        step(); step();
        abort = 1; proc_done = 1; p_dwe = 1; step();
        chk("abort_idle", obs[0].st, 0);
        chk("abort_no_tx_start", obs[0].ts, 0);
        chk("abort_dmem_we", obs[0].dwe, 0);
        step();
        chk("abort_no_tx_later", obs[0].ts, 0);
        $display("abort with proc_done: state=%0d", obs[0].st);

        // Port isolation by phase.
        start = 1; step();
        imem_rx_done = 1; step();
        p_dwe = 1; u_dwe = 0; #1;
        chk("iso_ld_dmem_we0", obs[0].dwe, 0);
        u_dwe = 1; new_byte = 1; #1;
        chk("iso_ld_dmem_we1", obs[0].dwe, 1);
        chk("iso_ld_data_byte", obs[0].ndb, 1);
        chk("iso_ld_ins_byte", obs[0].nib, 0);
        dmem_rx_done = 1; step();
        u_iwe = 1; new_byte = 1; p_dwe = 0; #1;
        chk("iso_ex_imem_we", obs[0].iwe, 0);
        chk("iso_ex_ins_byte", obs[0].nib, 0);
        chk("iso_ex_data_byte", obs[0].ndb, 0);
        chk("iso_ex_dmem_we", obs[0].dwe, 0);
        $display("mux isolation checked");

        // Reset during UNLOAD.
        proc_done = 1; step();
        chk("rst_unload_state", obs[0].st, 4);
        rstN = 0; step(); rstN = 1;
        u_dwe = 1; u_iwe = 1; new_byte = 1; #1;
        chk_obs("reset_mid_unload", 0, '0);
        chk_obs("reset_mid_unload", 1, '0);
        $display("reset in unload checked");

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rstN         = ($urandom_range(0, 499) != 0);
            start        = ($urandom_range(0, 3) == 0);
            abort        = ($urandom_range(0, 59) == 0);
            reload_imem  = $urandom_range(0, 1);
            imem_rx_done = ($urandom_range(0, 4) == 0);
            dmem_rx_done = ($urandom_range(0, 4) == 0);
            proc_done    = ($urandom_range(0, 29) == 0);
            dmem_tx_done = ($urandom_range(0, 4) == 0);
            new_byte     = $urandom_range(0, 1);
            u_da = DA'($urandom); p_da = DA'($urandom); u_dwd = DW'($urandom); p_dwd = DW'($urandom);
            u_ia = IA'($urandom); p_ia = IA'($urandom);
            u_dwe = $urandom_range(0, 1); p_dwe = $urandom_range(0, 1); u_iwe = $urandom_range(0, 1);
            prev_runs = m[0].runs;
            step();
            if (m[0].runs != prev_runs) $display("random run done at cycle %0d runs=%0d", c, m[0].runs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
